// File: rtl/vend_pkg.sv
// vend_pkg: state encoding, coin values and one-hot coin decode for vend_controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, PAYOUT} state_t;
  localparam int NICKLE_C = 5;
  localparam int DIME_C = 10;
  localparam int QUARTER_C = 25;
  typedef struct packed {
    logic valid;
    logic [4:0] value;
  } coin_t;
  function automatic coin_t coin_decode(input logic n, input logic d, input logic q);
    coin_t c;
    c.valid = (n ^ d ^ q) & ~(n & d & q);
    c.value = q ? 5'(QUARTER_C) : (d ? 5'(DIME_C) : 5'(NICKLE_C));
    return c;
  endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: coin acceptor, soda dispenser and change dispenser signals of vend_controller
interface vend_if #(parameter int CREDIT_W = 7);
  logic i_nickle, i_dime, i_quarter, i_cancel, i_soda_ack, i_coin_ack;
  logic o_soda, o_coin_valid, o_coin_dime, o_coin_reject, o_busy;
  logic [CREDIT_W-1:0] o_credit;
  modport master(
    output i_nickle, i_dime, i_quarter, i_cancel, i_soda_ack, i_coin_ack,
    input o_soda, o_coin_valid, o_coin_dime, o_coin_reject, o_busy, o_credit
  );
  modport slave(
    input i_nickle, i_dime, i_quarter, i_cancel, i_soda_ack, i_coin_ack,
    output o_soda, o_coin_valid, o_coin_dime, o_coin_reject, o_busy, o_credit
  );
endinterface

// File: rtl/vend_payout.sv
// vend_payout: change-dispenser handshake, pays loaded credit out one dime/nickel per ack
module vend_payout import vend_pkg::*; #(
  parameter int CREDIT_W = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic                i_coin_ack,
  output logic                o_coin_valid,
  output logic                o_coin_dime,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_done
);
  localparam logic [CREDIT_W-1:0] DIME_V = CREDIT_W'(DIME_C);
  localparam logic [CREDIT_W-1:0] NICKLE_V = CREDIT_W'(NICKLE_C);
  logic r_active;
  logic [CREDIT_W-1:0] r_credit;
  logic w_take;
  assign w_take = r_active & i_coin_ack;
  assign o_coin_valid = r_active;
  assign o_coin_dime = r_active & (r_credit >= DIME_V);
  assign o_credit = r_credit;
  assign o_done = w_take & (r_credit <= DIME_V);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_credit <= '0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_credit <= i_credit;
    end else if (w_take) begin
      r_active <= ~o_done;
      r_credit <= r_credit - (o_coin_dime ? DIME_V : NICKLE_V);
    end
  end
endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin credit, vend and change sequencer; VEND_TIMEOUT_EN adds inactivity auto-refund
module vend_controller import vend_pkg::*; #(
  parameter int PRICE = 20,
  parameter int CREDIT_W = 7,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic i_clk,
  input logic i_rst,
  vend_if.slave bus
);
  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
  if (PRICE <= 0 || PRICE % 5 != 0 || PRICE > 100) begin : g_bad_price
    $error("PRICE must be a non-zero multiple of 5, at most 100");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end
  state_t r_state, w_next;
  logic [CREDIT_W-1:0] r_credit, w_credit, w_sum, w_pay_credit;
  logic r_reject, w_cancel, w_accept, w_load, w_done;
  coin_t w_coin;
  assign w_coin = coin_decode(bus.i_nickle, bus.i_dime, bus.i_quarter);
  assign w_accept = w_coin.valid & (r_state == IDLE || r_state == COLLECT);
  assign w_sum = r_credit + CREDIT_W'(w_coin.value);
`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] r_timer;
  always_ff @(posedge i_clk) begin
    r_timer <= (i_rst || w_accept || r_state != COLLECT) ? '0 : r_timer + 1'b1;
  end
  assign w_cancel = bus.i_cancel | (r_state == COLLECT && r_timer == TW'(TIMEOUT_CYC - 1));
`else
  assign w_cancel = bus.i_cancel;
`endif
  // coin is credited before cancel is considered; reaching the price wins over cancel
  always_comb begin
    w_next = r_state;
    w_credit = r_credit;
    w_load = 1'b0;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (w_accept && w_sum >= PRICE_V) begin
          w_next = VEND;
          w_credit = w_sum - PRICE_V;
        end else if (w_accept) begin
          w_credit = w_sum;
          w_next = w_cancel ? PAYOUT : COLLECT;
          w_load = w_cancel;
        end else if (w_cancel && r_state == COLLECT) begin
          w_next = PAYOUT;
          w_load = 1'b1;
        end
      end
      VEND: begin
        if (bus.i_soda_ack) begin
          w_next = (|r_credit) ? PAYOUT : IDLE;
          w_load = |r_credit;
        end
      end
      PAYOUT: begin
        if (w_done) begin
          w_next = IDLE;
          w_credit = '0;
        end
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_credit <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state <= w_next;
      r_credit <= w_credit;
      r_reject <= (bus.i_nickle | bus.i_dime | bus.i_quarter) & ~w_accept;
    end
  end
  vend_payout #(.CREDIT_W(CREDIT_W)) u_payout (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_credit    (w_credit),
    .i_coin_ack  (bus.i_coin_ack),
    .o_coin_valid(bus.o_coin_valid),
    .o_coin_dime (bus.o_coin_dime),
    .o_credit    (w_pay_credit),
    .o_done      (w_done)
  );
  assign bus.o_soda = r_state == VEND;
  assign bus.o_busy = r_state == VEND || r_state == PAYOUT;
  assign bus.o_coin_reject = r_reject;
  assign bus.o_credit = (r_state == PAYOUT) ? w_pay_credit : r_credit;
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: scoreboard bench; directed stimulus pushes expected events, negedge monitor pops and compares
module tb_vend_controller;
  localparam int CW = 7;
  typedef enum int {E_REJ, E_CRED, E_SODA, E_COIN, E_DONE} ev_t;
  typedef struct {
    ev_t kind;
    logic [7:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];
  logic mon_en = 1'b0, p_busy = 1'b0, p_soda = 1'b0;
  logic [CW-1:0] p_credit = '0;
  vend_if #(.CREDIT_W(CW)) bus();
  vend_controller #(.PRICE(20), .CREDIT_W(CW), .TIMEOUT_CYC(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic ex(input ev_t k, input logic d, input logic [CW-1:0] c);
    exp_t e;
    e.kind = k;
    e.data = {d, c};
    sb.push_back(e);
  endtask
  task automatic check(input ev_t k, input logic [7:0] got);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got %s data=%0d, required no event", k.name(), got);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.data != got) begin
        mismatched++;
        $display("FAIL event: got %s data=%0d, required %s data=%0d", k.name(), got, e.kind.name(), e.data);
      end
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_coin_reject) check(E_REJ, {1'b0, bus.o_credit});
      if (!bus.o_busy && !p_busy && bus.o_credit != p_credit) check(E_CRED, {1'b0, bus.o_credit});
      if (bus.o_soda && !p_soda) check(E_SODA, {1'b0, bus.o_credit});
      if (bus.o_coin_valid && bus.i_coin_ack) check(E_COIN, {bus.o_coin_dime, bus.o_credit});
      if (!bus.o_busy && p_busy) check(E_DONE, {1'b0, bus.o_credit});
      p_busy <= bus.o_busy;
      p_soda <= bus.o_soda;
      p_credit <= bus.o_credit;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic coin(input logic n, input logic d, input logic q, input logic c);
    bus.i_nickle = n;
    bus.i_dime = d;
    bus.i_quarter = q;
    bus.i_cancel = c;
    tick();
    bus.i_nickle = 1'b0;
    bus.i_dime = 1'b0;
    bus.i_quarter = 1'b0;
    bus.i_cancel = 1'b0;
  endtask
  task automatic wait_hi(input bit sel, input string nm);
    int k = 0;
    while (!(sel ? bus.o_coin_valid : bus.o_soda) && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) begin
      compared++;
      mismatched++;
      $display("FAIL timeout_%s: still 0 after 20 cycles, required 1", nm);
    end
  endtask
  task automatic soda_ack();
    wait_hi(1'b0, "soda");
    bus.i_soda_ack = 1'b1;
    tick();
    bus.i_soda_ack = 1'b0;
  endtask
  task automatic coin_ack(input int dly);
    wait_hi(1'b1, "coin_valid");
    idle(dly);
    bus.i_coin_ack = 1'b1;
    tick();
    bus.i_coin_ack = 1'b0;
  endtask
  task automatic check_idle(input string nm);
    logic [CW+4:0] got;
    got = {bus.o_soda, bus.o_coin_valid, bus.o_coin_dime, bus.o_coin_reject, bus.o_busy, bus.o_credit};
    compared++;
    if (got != '0) begin
      mismatched++;
      $display("FAIL %s: outputs {soda,valid,dime,reject,busy,credit}=%b, required all 0", nm, got);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  initial begin
    bus.i_nickle = 1'b0;
    bus.i_dime = 1'b0;
    bus.i_quarter = 1'b0;
    bus.i_cancel = 1'b0;
    bus.i_soda_ack = 1'b0;
    bus.i_coin_ack = 1'b0;
    idle(2);
    check_idle("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    // quarter: vend, 5 change as one nickel
    ex(E_SODA, 0, 5); ex(E_COIN, 0, 5); ex(E_DONE, 0, 0);
    coin(0, 0, 1, 0); soda_ack(); coin_ack(0); idle(3);
    // dime, dime: exact price, no change
    ex(E_CRED, 0, 10); ex(E_SODA, 0, 0); ex(E_DONE, 0, 0);
    coin(0, 1, 0, 0); coin(0, 1, 0, 0); soda_ack(); idle(3);
    // nickel, quarter: 10 change as one dime
    ex(E_CRED, 0, 5); ex(E_SODA, 0, 10); ex(E_COIN, 1, 10); ex(E_DONE, 0, 0);
    coin(1, 0, 0, 0); coin(0, 0, 1, 0); soda_ack(); coin_ack(0); idle(3);
    // coins during VEND are rejected
    ex(E_CRED, 0, 10); ex(E_SODA, 0, 0); ex(E_REJ, 0, 0); ex(E_REJ, 0, 0); ex(E_DONE, 0, 0);
    coin(0, 1, 0, 0); coin(0, 1, 0, 0); coin(0, 0, 1, 0); coin(0, 1, 0, 0); soda_ack(); idle(3);
    // cancel at 15 with slow acks: dime then nickel
    ex(E_CRED, 0, 5); ex(E_CRED, 0, 15); ex(E_COIN, 1, 15); ex(E_COIN, 0, 5); ex(E_DONE, 0, 0);
    coin(1, 0, 0, 0); coin(0, 1, 0, 0); coin(0, 0, 0, 1); coin_ack(3); coin_ack(3); idle(3);
    // multi-coin pulses rejected, credit unchanged
    ex(E_REJ, 0, 0); ex(E_CRED, 0, 10); ex(E_REJ, 0, 10); ex(E_REJ, 0, 10);
    coin(1, 1, 0, 0); coin(0, 1, 0, 0); coin(0, 1, 1, 0); coin(1, 1, 1, 0);
    // reset in the middle of a 10-cent payout
    ex(E_DONE, 0, 0);
    coin(0, 0, 0, 1); wait_hi(1'b1, "coin_valid");
    rst = 1'b1; tick(); check_idle("reset_in_payout"); rst = 1'b0;
    idle(5); check_idle("after_reset");
    // cancel in IDLE and stray acks are ignored
    coin(0, 0, 0, 1);
    bus.i_soda_ack = 1'b1; bus.i_coin_ack = 1'b1; tick(); bus.i_soda_ack = 1'b0; bus.i_coin_ack = 1'b0;
    idle(2); check_idle("cancel_idle");
    // nickel with cancel from IDLE: straight to payout of 5
    ex(E_COIN, 0, 5); ex(E_DONE, 0, 0);
    coin(1, 0, 0, 1); coin_ack(0); idle(3);
    // dime then dime with cancel: price reached, cancel dropped
    ex(E_CRED, 0, 10); ex(E_SODA, 0, 0); ex(E_DONE, 0, 0);
    coin(0, 1, 0, 0); coin(0, 1, 0, 1); soda_ack(); idle(3);
    // inactivity: auto refund with timeout, otherwise COLLECT persists until cancel
    ex(E_CRED, 0, 10); ex(E_COIN, 1, 10); ex(E_DONE, 0, 0);
    coin(0, 1, 0, 0);
`ifdef VEND_TIMEOUT_EN
    coin_ack(0);
`else
    idle(12);
    compared++;
    if (bus.o_busy !== 1'b0 || bus.o_credit !== 7'd10) begin
      mismatched++;
      $display("FAIL collect_persist: busy=%b credit=%0d, required busy=0 credit=10", bus.o_busy, bus.o_credit);
    end
    coin(0, 0, 0, 1); coin_ack(0);
`endif
    idle(5);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_events: %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing controller for the coin-operated soda datapath.
- Accepts one-hot coin pulses and accumulates credit against a programmable price.
- On reaching the price, hands the soda dispenser a request/acknowledge vend and then pays out change coin-by-coin through a change-dispenser handshake.
- Also supports a customer cancel (full refund). Sits between the coin acceptor and the soda/change actuators.

Parameters:
- PRICE, 20, item price in cents; must be a non-zero multiple of 5, at most 100.
- CREDIT_W, 7, width of the credit/change register in cents (holds up to PRICE+20).
- TIMEOUT_CYC, 1000, inactivity cycles before auto-refund (used only with VEND_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_nickle  in  1  single-cycle pulse: 5-cent coin inserted.
- i_dime  in  1  single-cycle pulse: 10-cent coin inserted.
- i_quarter  in  1  single-cycle pulse: 25-cent coin inserted.
- i_cancel  in  1  level/pulse: customer requests refund.
- i_soda_ack  in  1  soda dispenser has dropped one can.
- i_coin_ack  in  1  change dispenser has ejected the presented coin.
- o_soda  out  1  vend request, held until i_soda_ack.
- o_coin_valid  out  1  change coin request, held until i_coin_ack.
- o_coin_dime  out  1  type of presented change coin: 1 = dime, 0 = nickel; stable while o_coin_valid.
- o_coin_reject  out  1  one-cycle pulse: inserted coin routed to the return chute, not credited.
- o_credit  out  CREDIT_W  current credit (COLLECT) or remaining change (VEND/PAYOUT), in cents.
- o_busy  out  1  high in VEND and PAYOUT.

Behaviour:
- Reset (sync, i_rst high at the edge): state IDLE, credit 0, all outputs 0. Reset mid-vend or mid-payout abandons the transaction; no further requests are issued.
- States: IDLE (credit == 0), COLLECT (0 < credit < PRICE), VEND, PAYOUT.
- Coin decode: exactly one of the three coin inputs high = valid coin of 5/10/25. Two or more high = invalid: o_coin_reject pulses the next cycle and credit is unchanged.
- IDLE/COLLECT, valid coin in cycle N: sum = credit + coin.
  - If sum >= PRICE: state VEND in N+1 with credit = sum - PRICE (change owed); o_soda = 1 from N+1.
  - Else: state COLLECT, credit = sum in N+1.
- Cancel in COLLECT (no coin): state PAYOUT in the next cycle, credit unchanged.
- Cancel in IDLE: ignored.
- Coin and cancel in the same cycle: coin credited first. If the sum reaches PRICE, go to VEND and drop the cancel; otherwise go to PAYOUT with credit = sum.
- VEND: o_soda held until i_soda_ack is sampled high. Next cycle: PAYOUT if credit > 0, else IDLE; o_soda deasserts.
- PAYOUT:
  - o_coin_valid = 1 with o_coin_dime = (credit >= 10).
  - On i_coin_ack, credit -= 10 or 5 in the next cycle and the type is re-evaluated.
  - When credit reaches 0, go to IDLE and deassert o_coin_valid in that same cycle.
  - o_coin_valid stays high across back-to-back coins; one coin per acked cycle.
- Coins arriving during VEND/PAYOUT: not credited; o_coin_reject pulses the next cycle. i_cancel ignored.
- Acks outside their request window are ignored.
- All arithmetic is unsigned, CREDIT_W bits. Credit is always a multiple of 5 and never underflows.

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- When defined: a counter resets on every valid coin and increments each cycle in COLLECT. When it reaches TIMEOUT_CYC-1, the block behaves as if i_cancel were asserted that cycle, so refund starts the next cycle.
- When undefined: no counter; COLLECT persists indefinitely.

Decomposition:
- Package vend_pkg holds:
  - the state enum (IDLE, COLLECT, VEND, PAYOUT);
  - coin value constants NICKLE_C = 5, DIME_C = 10, QUARTER_C = 25;
  - a coin-decode function returning value and a valid flag.
- Natural sub-module: vend_payout, the change-dispenser handshake and decrement unit (takes load/credit, drives o_coin_valid/o_coin_dime, reports done).

Test Plan:
- Quarter from IDLE, PRICE = 20 -> o_soda next cycle, credit 5. Ack -> PAYOUT, one nickel (o_coin_dime = 0). Ack -> IDLE, credit 0.
- Dime, dime -> credit 10 then VEND with credit 0. Ack -> IDLE directly, o_coin_valid never asserted.
- Nickel, quarter -> VEND with change 10 -> single dime out. Dime, dime, quarter during VEND -> o_coin_reject pulses, credit stays 0.
- Nickel, dime, cancel -> PAYOUT 15 -> dime then nickel. Acks delayed 3 cycles each -> o_coin_valid held steady, o_coin_dime stable until ack.
- i_nickle and i_dime high together -> o_coin_reject pulses, credit unchanged. i_rst during PAYOUT with credit 10 -> all outputs 0, IDLE next cycle.
- VEND_TIMEOUT_EN, TIMEOUT_CYC = 8: insert one dime, then idle 8 cycles -> PAYOUT begins, one dime returned.
